// File: rtl/dac_amp_envelope_if.sv
// Control, sample and status bundle for dac_amp_envelope.
// slave = the envelope block, master = whatever drives it.
interface dac_amp_envelope_if;
    logic        enable;
    logic        dac_ready;
    logic        dac_ready_negedge;
    logic [15:0] gain_target;
    logic [15:0] ramp_step;
    logic [63:0] din_da0i;
    logic [63:0] din_da0q;
    logic [63:0] din_da1i;
    logic [63:0] din_da1q;
    logic [63:0] da0i;
    logic [63:0] da0q;
    logic [63:0] da1i;
    logic [63:0] da1q;
    logic [15:0] gain_o;
    logic [2:0]  state_o;
    logic        mute_flag;

    modport master (
        output enable, dac_ready, dac_ready_negedge, gain_target, ramp_step,
        output din_da0i, din_da0q, din_da1i, din_da1q,
        input  da0i, da0q, da1i, da1q, gain_o, state_o, mute_flag
    );

    modport slave (
        input  enable, dac_ready, dac_ready_negedge, gain_target, ramp_step,
        input  din_da0i, din_da0q, din_da1i, din_da1q,
        output da0i, da0q, da1i, da1q, gain_o, state_o, mute_flag
    );
endinterface

// File: rtl/dac_amp_envelope.sv
// Ramped amplitude envelope for 4-parallel DAC0/DAC1 I/Q samples, with link-loss muting.
// Output = round_half_up(sample * gain / 2^15), saturated to 16 bit, 3 clocks after input.
module dac_amp_envelope #(
    parameter logic [15:0] GAIN_ONE = 16'h8000,
    parameter int          PIPE_LAT = 3
) (
    input logic               clk_user_bufg,
    input logic               rst,
    dac_amp_envelope_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD      = 3'd2,
        RAMP_DOWN = 3'd3,
        MUTE      = 3'd4
    } state_t;

    localparam int LANES = 16;

    if (PIPE_LAT != 3) begin : g_lat_check
        $error("dac_amp_envelope: datapath latency is fixed at 3 clocks");
    end

    state_t      state, state_nxt;
    logic [15:0] gain, gain_nxt;
    logic [15:0] tgt, step, floor_g, up_val, down_val;
    logic [16:0] up_sum, dn_diff;
    logic        mute_req, flush;

    assign tgt      = (bus.gain_target > GAIN_ONE) ? GAIN_ONE : bus.gain_target;
    assign step     = (bus.ramp_step == 16'd0) ? 16'd1 : bus.ramp_step;
    assign floor_g  = bus.enable ? tgt : 16'd0;

    // 17-bit arithmetic so neither direction can wrap before clamping
    assign up_sum   = {1'b0, gain} + {1'b0, step};
    assign up_val   = (up_sum > {1'b0, tgt}) ? tgt : up_sum[15:0];
    assign dn_diff  = {1'b0, gain} - {1'b0, step};
    assign down_val = (dn_diff[16] || (dn_diff[15:0] < floor_g)) ? floor_g : dn_diff[15:0];

    assign mute_req = (state != MUTE) && (!bus.dac_ready || bus.dac_ready_negedge);
    assign flush    = mute_req || (state == MUTE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_user_bufg or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gain  <= '0;
        end else begin
            state <= state_nxt;
            gain  <= gain_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        if (mute_req) begin
            state_nxt = MUTE;
        end else begin
            case (state)
                IDLE:      if (bus.enable && bus.dac_ready) state_nxt = RAMP_UP;
                RAMP_UP: begin
                    if (!bus.enable || (tgt < gain)) state_nxt = RAMP_DOWN;
                    else if (up_val == tgt)          state_nxt = HOLD;
                end
                HOLD: begin
                    if (!bus.enable || (tgt < gain)) state_nxt = RAMP_DOWN;
                    else if (tgt > gain)             state_nxt = RAMP_UP;
                end
                RAMP_DOWN: begin
                    if (gain == floor_g)                state_nxt = (floor_g == 16'd0) ? IDLE : HOLD;
                    else if (bus.enable && (tgt > gain)) state_nxt = RAMP_UP;
                end
                MUTE:      if (!bus.enable && bus.dac_ready) state_nxt = IDLE;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    // Gain only moves while staying in a ramp; direction changes hold it for one clock
    always_comb begin
        gain_nxt = gain;
        if ((state_nxt == MUTE) || (state == IDLE) || (state == MUTE)) begin
            gain_nxt = '0;
        end else if ((state == RAMP_UP) && (state_nxt != RAMP_DOWN)) begin
            gain_nxt = up_val;
        end else if ((state == RAMP_DOWN) && (state_nxt == RAMP_DOWN)) begin
            gain_nxt = down_val;
        end
    end

    function automatic logic [32:0] lane_mul(input logic [15:0] s, input logic [15:0] g);
        logic signed [32:0] a, b;
        a = {{17{s[15]}}, s};
        b = {17'd0, g};
        return a * b;
    endfunction

    function automatic logic [15:0] lane_round_sat(input logic [32:0] p);
        logic signed [32:0] r;
        r = ($signed(p) + 33'sd16384) >>> 15;
        if (r > 33'sd32767)       return 16'h7fff;
        else if (r < -33'sd32768) return 16'h8000;
        else                      return r[15:0];
    endfunction

    logic [255:0]            din_all, din_r, dout_r;
    logic [15:0]             gain_r;
    logic [LANES-1:0][32:0]  prod_r;

    assign din_all = {bus.din_da1q, bus.din_da1i, bus.din_da0q, bus.din_da0i};

    // NOTE: the product array is reset like any register because downstream expects zeros after reset.
    always_ff @(posedge clk_user_bufg or posedge rst) begin
        if (rst) begin
            din_r  <= '0;
            gain_r <= '0;
            prod_r <= '0;
            dout_r <= '0;
        end else if (flush) begin
            din_r  <= '0;
            gain_r <= '0;
            prod_r <= '0;
            dout_r <= '0;
        end else begin
            din_r  <= din_all;
            gain_r <= gain;
            for (int k = 0; k < LANES; k++) begin
                prod_r[k]          <= lane_mul(din_r[16*k +: 16], gain_r);
                dout_r[16*k +: 16] <= lane_round_sat(prod_r[k]);
            end
        end
    end

    assign bus.da0i      = dout_r[63:0];
    assign bus.da0q      = dout_r[127:64];
    assign bus.da1i      = dout_r[191:128];
    assign bus.da1q      = dout_r[255:192];
    assign bus.gain_o    = gain;
    assign bus.state_o   = state;
    assign bus.mute_flag = (state == MUTE);
endmodule
